// File: rtl/pixel_array_readout.sv
// pixel_array_readout
//
// Frame sequencer for a digitally modelled pixel array. One frame runs
// ERASE -> EXPOSE -> [CONV_CORR] -> CONV_DATA -> READ -> IDLE. During a
// conversion a shared ramp counter sweeps 0..2^W-1. Each pixel's comparator
// latches the ramp value on the cycle the ramp equals that pixel's level.
// READ streams the per-pixel results over a valid/ready handshake.
//
// Optional feature macro: READOUT_CDS_EN
//   defined   : a reset-level conversion (CONV_CORR) runs before the signal
//               conversion, and pixel_data = max(data_lat - corr_lat, 0).
//   undefined : CONV_CORR is skipped, corr_values is ignored and
//               pixel_data = data_lat.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   start         frame request, only honoured in IDLE
//   pixel_values  packed per-pixel signal levels, pixel i at [i*W +: W]
//   corr_values   packed per-pixel reset levels, pixel i at [i*W +: W]
//   busy          high in every state except IDLE
//   erase         high in ERASE
//   expose        high in EXPOSE
//   convert       high in CONV_CORR and CONV_DATA
//   ramp          current ramp counter value
//   pixel_valid   readout data valid
//   pixel_ready   downstream accept
//   pixel_data    result for the pixel at pixel_index
//   pixel_index   index of the pixel being presented
//   frame_last    high with pixel_valid on the last pixel
module pixel_array_readout #(
  parameter int PIXEL_COUNT   = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int EXPOSE_CYCLES = 16,
  localparam int W     = COUNTER_WIDTH,
  localparam int IDX_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PIXEL_COUNT*W-1:0] pixel_values,
  input  logic [PIXEL_COUNT*W-1:0] corr_values,
  output logic                     busy,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [W-1:0]             ramp,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [W-1:0]             pixel_data,
  output logic [IDX_W-1:0]         pixel_index,
  output logic                     frame_last
);

  // Sized so that EXPOSE_CYCLES = 1 still yields a 1-bit counter.
  localparam int EXP_W = $clog2(EXPOSE_CYCLES + 1);
  localparam logic [EXP_W-1:0] EXP_LAST = EXP_W'(EXPOSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [W-1:0]     RAMP_MAX = {W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONV_CORR,
    S_CONV_DATA,
    S_READ
  } state_t;

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [W-1:0]     ramp_q, ramp_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             erase_q, erase_d;
  logic             expose_q, expose_d;
  logic             convert_q, convert_d;
  logic             last_q, last_d;

  logic [W-1:0] data_lat_q [PIXEL_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      exp_cnt_q <= '0;
      ramp_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_cnt_q <= exp_cnt_d;
      ramp_q    <= ramp_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      convert_q <= convert_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_cnt_d = exp_cnt_q;
    ramp_d    = ramp_q;
    valid_d   = valid_q;
    idx_d     = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ERASE;
      end
      S_ERASE: begin
        state_d   = S_EXPOSE;
        exp_cnt_d = '0;
      end
      S_EXPOSE: begin
        if (exp_cnt_q == EXP_LAST) begin
`ifdef READOUT_CDS_EN
          state_d = S_CONV_CORR;
`else
          state_d = S_CONV_DATA;
`endif
          exp_cnt_d = '0;
          ramp_d    = '0;
        end else begin
          exp_cnt_d = exp_cnt_q + EXP_W'(1);
        end
      end
`ifdef READOUT_CDS_EN
      S_CONV_CORR: begin
        // The ramp wraps back to 0 on its own as it leaves the last code.
        ramp_d = ramp_q + W'(1);
        if (ramp_q == RAMP_MAX) state_d = S_CONV_DATA;
      end
`endif
      S_CONV_DATA: begin
        ramp_d = ramp_q + W'(1);
        if (ramp_q == RAMP_MAX) begin
          state_d = S_READ;
          valid_d = 1'b1;
          idx_d   = '0;
        end
      end
      S_READ: begin
        // After the last handshake READ holds one more cycle with valid low,
        // so busy drops one cycle after the final transfer.
        if (valid_q) begin
          if (pixel_ready) begin
            if (idx_q == IDX_LAST) valid_d = 1'b0;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Phase outputs are decoded from the next state so they register on the
    // same edge as the state itself.
    busy_d    = (state_d != S_IDLE);
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    convert_d = (state_d == S_CONV_CORR) || (state_d == S_CONV_DATA);
    last_d    = valid_d && (idx_d == IDX_LAST);
  end

  // Per-pixel signal-level comparators.
  for (genvar gi = 0; gi < PIXEL_COUNT; gi++) begin : g_data_lat
    always_ff @(posedge clk) begin
      if (reset || state_q == S_ERASE) begin
        data_lat_q[gi] <= '0;
      end else if (state_q == S_CONV_DATA &&
                   ramp_q == pixel_values[gi*W +: W]) begin
        data_lat_q[gi] <= ramp_q;
      end
    end
  end

`ifdef READOUT_CDS_EN
  logic [W-1:0] corr_lat_q [PIXEL_COUNT];

  // Per-pixel reset-level comparators.
  for (genvar gi = 0; gi < PIXEL_COUNT; gi++) begin : g_corr_lat
    always_ff @(posedge clk) begin
      if (reset || state_q == S_ERASE) begin
        corr_lat_q[gi] <= '0;
      end else if (state_q == S_CONV_CORR &&
                   ramp_q == corr_values[gi*W +: W]) begin
        corr_lat_q[gi] <= ramp_q;
      end
    end
  end

  logic [W-1:0] sel_data, sel_corr;
  always_comb begin
    sel_data   = data_lat_q[idx_q];
    sel_corr   = corr_lat_q[idx_q];
    // Offset above signal would underflow; clamp to black instead.
    pixel_data = (sel_corr > sel_data) ? '0 : (sel_data - sel_corr);
  end
`else
  logic unused_corr;
  assign unused_corr = ^corr_values;
  assign pixel_data  = data_lat_q[idx_q];
`endif

  assign busy        = busy_q;
  assign erase       = erase_q;
  assign expose      = expose_q;
  assign convert     = convert_q;
  assign ramp        = ramp_q;
  assign pixel_valid = valid_q;
  assign pixel_index = idx_q;
  assign frame_last  = last_q;

endmodule

// File: tb/tb_pixel_array_readout.sv
module tb_pixel_array_readout;
  localparam int N = 4;
  localparam int W = 8;
  localparam int E = 16;
`ifdef READOUT_CDS_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam int FIRST  = 2 + E + K * (1 << W);
  localparam int BUDGET = 3000;

  logic           clk = 1'b0;
  logic           reset, start, pixel_ready;
  logic [N*W-1:0] pixel_values, corr_values;
  logic           busy, erase, expose, convert, pixel_valid, frame_last;
  logic [W-1:0]   ramp, pixel_data;
  logic [1:0]     pixel_index;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_array_readout #(
    .PIXEL_COUNT(N), .COUNTER_WIDTH(W), .EXPOSE_CYCLES(E)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pixel_values(pixel_values), .corr_values(corr_values),
    .busy(busy), .erase(erase), .expose(expose), .convert(convert),
    .ramp(ramp), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_data(pixel_data), .pixel_index(pixel_index), .frame_last(frame_last)
  );

  typedef struct {
    logic [N*W-1:0] pv;
    logic [N*W-1:0] cv;
    logic [N*W-1:0] exp;
    int             stall_at;
    int             stall_len;
    int             pulse_at;
    bit             hold;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Expected readout: CDS result clamped at zero, or the raw level.
  function automatic logic [N*W-1:0] model(input logic [N*W-1:0] pv, cv);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) begin
      int p, c;
      p = int'(pv[i*W +: W]);
      c = int'(cv[i*W +: W]);
`ifdef READOUT_CDS_EN
      r[i*W +: W] = (p >= c) ? W'(p - c) : '0;
`else
      r[i*W +: W] = W'(p);
      c = c;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [N*W-1:0] pv, cv, expv,
                           input int stall_at, stall_len, pulse_at,
                           input bit hold);
    int n, first_v, idx_e, stall_rem, conv_cnt, busy_low;
    @(negedge clk);
    pixel_values = pv; corr_values = cv; pixel_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    n = 0; first_v = -1; idx_e = 0; stall_rem = stall_len;
    conv_cnt = 0; busy_low = -1;
    while (busy_low < 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (convert) conv_cnt++;
      start = hold || (n == pulse_at);
      if (!busy) begin
        busy_low = n;
      end else if (pixel_valid) begin
        if (first_v < 0) begin
          first_v = n;
          check("first_valid_cycle", n, FIRST);
        end
        if (idx_e < N) begin
          check("pixel_index", int'(pixel_index), idx_e);
          check("pixel_data", int'(pixel_data), int'(expv[idx_e*W +: W]));
          check("frame_last", int'(frame_last), int'(idx_e == N - 1));
        end else begin
          n_vec++; n_err++;
          $display("FAIL extra_pixel: got index %0d, required no valid", pixel_index);
        end
        if (idx_e == stall_at && stall_rem > 0) begin
          pixel_ready = 1'b0;
          stall_rem--;
        end else begin
          pixel_ready = 1'b1;
          $display("pixel idx=%0d data=%0d last=%0b cycle=%0d",
                   pixel_index, pixel_data, frame_last, n);
          idx_e++;
        end
      end else begin
        pixel_ready = 1'b1;
      end
    end
    check("pixels_transferred", idx_e, N);
    check("busy_low_cycle", busy_low, FIRST + N + stall_len + 1);
    check("convert_cycles", conv_cnt, K * (1 << W));
    if (hold) begin
      @(negedge clk);
      check("restart_erase", int'(erase), 1);
      check("restart_busy", int'(busy), 1);
      do_reset();
    end else begin
      repeat (3) @(negedge clk);
      check("stays_idle", int'(busy), 0);
    end
  endtask

  task automatic run_abort(input logic [N*W-1:0] pv, cv, input int at,
                           input int exp_ramp, exp_idx, exp_valid);
    @(negedge clk);
    pixel_values = pv; corr_values = cv; pixel_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (at) @(negedge clk);
    check("abort_ramp_before", int'(ramp), exp_ramp);
    check("abort_index_before", int'(pixel_index), exp_idx);
    check("abort_valid_before", int'(pixel_valid), exp_valid);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(pixel_valid), 0);
    check("abort_ramp", int'(ramp), 0);
    check("abort_convert", int'(convert), 0);
    check("abort_index", int'(pixel_index), 0);
    check("abort_data", int'(pixel_data), 0);
    reset = 1'b0;
    $display("abort at cycle %0d done", at);
  endtask

  initial begin
    logic [N*W-1:0] pv, cv;

    tbl[0] = '{pack4(200, 100, 50, 255), pack4(10, 10, 60, 0),
`ifdef READOUT_CDS_EN
               pack4(190, 90, 0, 255),
`else
               pack4(200, 100, 50, 255),
`endif
               -1, 0, 0, 1'b0};
    tbl[1] = tbl[0];
    tbl[1].stall_at = 1; tbl[1].stall_len = 5;
    tbl[2] = '{pack4(0, 255, 0, 255), pack4(0, 0, 0, 0),
               pack4(0, 255, 0, 255), -1, 0, 0, 1'b0};
    tbl[3] = '{pack4(7, 8, 9, 10), pack4(1, 2, 3, 4),
`ifdef READOUT_CDS_EN
               pack4(6, 6, 6, 6),
`else
               pack4(7, 8, 9, 10),
`endif
               -1, 0, 5, 1'b0};
    tbl[4] = tbl[0];
    tbl[4].hold = 1'b1;

    reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    pixel_values = '0; corr_values = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_erase", int'(erase), 0);
    check("rst_expose", int'(expose), 0);
    check("rst_convert", int'(convert), 0);
    check("rst_ramp", int'(ramp), 0);
    check("rst_valid", int'(pixel_valid), 0);
    check("rst_data", int'(pixel_data), 0);
    check("rst_index", int'(pixel_index), 0);
    check("rst_last", int'(frame_last), 0);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].pv, tbl[t].cv, tbl[t].exp, tbl[t].stall_at,
                tbl[t].stall_len, tbl[t].pulse_at, tbl[t].hold);
    end

    for (int r = 0; r < 4; r++) begin
      pv = $urandom;
      cv = $urandom;
      run_frame(pv, cv, model(pv, cv), int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, 3)), 0, 1'b0);
    end

    run_abort(tbl[0].pv, tbl[0].cv, 2 + E + (K - 1) * (1 << W) + 100, 100, 0, 0);
    run_frame(tbl[0].pv, tbl[0].cv, tbl[0].exp, -1, 0, 0, 1'b0);
    run_abort(tbl[0].pv, tbl[0].cv, FIRST + 2, 0, 2, 1);
    run_frame(tbl[0].pv, tbl[0].cv, tbl[0].exp, -1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
